// File: rtl/spi_slave_param_if.sv
// Bus bundle for spi_slave_param: SPI pins, transmit handshake, receive
// strobe and frame status. The slave modport is the view seen by the block
// itself; the master modport is the view of the SPI master plus on-chip user.
interface spi_slave_param_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cpol;
  logic                  cpha;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ack;
  logic                  tx_underrun;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  frame_done;
  logic                  frame_err;
  logic                  miso;
  logic                  miso_oe;
  logic                  ss;
  logic                  sck;
  logic                  mosi;

  modport slave (
    input  cpol, cpha, tx_data, tx_valid, ss, sck, mosi,
    output tx_ack, tx_underrun, rx_data, rx_valid, busy,
           frame_done, frame_err, miso, miso_oe
  );

  modport master (
    output cpol, cpha, tx_data, tx_valid, ss, sck, mosi,
    input  tx_ack, tx_underrun, rx_data, rx_valid, busy,
           frame_done, frame_err, miso, miso_oe
  );
endinterface

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave, all four modes, multi-word bursts per ss frame.
// SPI pins are oversampled in the clk domain; edges are found on the
// synchronised sck. Transmit words come through a valid/ack handshake.
module spi_slave_param #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  spi_slave_param_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic                  sck_prev, ss_prev;
  logic                  cpol_l, cpha_l;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift, rx_shift, rx_next, rx_data_q, load_word;
  logic                  miso_q, tx_ack_q, tx_underrun_q, rx_valid_q;
  logic                  frame_done_q, frame_err_q;
  logic                  sck_s, ss_s, mosi_s;
  logic                  sck_rise, sck_fall, lead_edge, trail_edge;
  logic                  sample_edge, shift_edge, ss_fall, ss_rise;
  logic                  word_last, start_load, burst_load, do_load, load_cpha;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  // Synchronise the SPI pins and keep one cycle of history for edge detection.
  // ss history resets low, so a frame already running when reset releases
  // produces no falling edge until ss has been seen high again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      ss_prev   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, so the synchroniser chain shifts by exactly one stage per clk.
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
      ss_prev   <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sck_rise    = ~sck_prev & sck_s;
  assign sck_fall    = sck_prev & ~sck_s;
  assign ss_fall     = ss_prev & ~ss_s;
  assign ss_rise     = ~ss_prev & ss_s;
  assign lead_edge   = cpol_l ? sck_fall : sck_rise;
  assign trail_edge  = cpol_l ? sck_rise : sck_fall;
  assign sample_edge = cpha_l ? trail_edge : lead_edge;
  assign shift_edge  = cpha_l ? lead_edge : trail_edge;

  assign rx_next    = MSB_FIRST ? {rx_shift[DATA_WIDTH-2:0], mosi_s}
                                : {mosi_s, rx_shift[DATA_WIDTH-1:1]};
  assign word_last  = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign start_load = (state_q == IDLE) && ss_fall;
  assign burst_load = (state_q == ACTIVE) && !ss_rise && sample_edge && word_last;
  assign do_load    = start_load || burst_load;
  // At frame start the mode is latched in the same cycle, so use the pin.
  assign load_cpha  = (state_q == IDLE) ? bus.cpha : cpha_l;
  assign load_word  = bus.tx_valid ? bus.tx_data : '0;

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: ss falling opens a frame, ss rising closes it.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = ACTIVE;
      ACTIVE:  if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: shifting, bit counting, word loads and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_l        <= 1'b0;
      cpha_l        <= 1'b0;
      bit_cnt       <= '0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      rx_data_q     <= '0;
      miso_q        <= 1'b0;
      tx_ack_q      <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_valid_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      tx_ack_q      <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_valid_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (ss_fall) begin
            cpol_l  <= bus.cpol;
            cpha_l  <= bus.cpha;
            bit_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            // ss wins over any sck edge seen in the same cycle.
            frame_done_q <= 1'b1;
            frame_err_q  <= (bit_cnt != '0);
            bit_cnt      <= '0;
            miso_q       <= 1'b0;
          end else if (sample_edge) begin
            rx_shift <= rx_next;
            if (word_last) begin
              rx_data_q  <= rx_next;
              rx_valid_q <= 1'b1;
              bit_cnt    <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (shift_edge && (cpha_l || bit_cnt != '0)) begin
            // In CPHA=0 the trailing edge after a completed word must not
            // disturb the first bit already presented by the word load.
            miso_q   <= first_bit(tx_shift);
            tx_shift <= shift_out(tx_shift);
          end
        end
        default: ;
      endcase
      if (do_load) begin
        tx_ack_q      <= bus.tx_valid;
        tx_underrun_q <= ~bus.tx_valid;
        if (!load_cpha) begin
          miso_q   <= first_bit(load_word);
          tx_shift <= shift_out(load_word);
        end else begin
          tx_shift <= load_word;
        end
      end
    end
  end

  assign bus.tx_ack      = tx_ack_q;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.busy        = (state_q == ACTIVE);
  assign bus.miso_oe     = (state_q == ACTIVE);
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.miso        = miso_q;
endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: an 8-bit MSB-first and a 16-bit
// LSB-first instance share sck/mosi/cpol/cpha, each has its own ss.
module tb_spi_slave_param;
  localparam int HALF = 10;  // sck half period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic sck = 1'b0, mosi = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic ss8 = 1'b1, ss16 = 1'b1, sel16 = 1'b0;

  spi_slave_param_if #(.DATA_WIDTH(8))  if8 ();
  spi_slave_param_if #(.DATA_WIDTH(16)) if16 ();

  spi_slave_param #(.DATA_WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8));
  spi_slave_param #(.DATA_WIDTH(16), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16));

  // Transmit word rings; the monitor advances the read index on tx_ack.
  logic [7:0]  tx8_words[8];
  logic [15:0] tx16_words[8];
  int tx8_n = 0, tx8_idx = 0, tx16_n = 0, tx16_idx = 0;

  assign if8.sck = sck;   assign if8.mosi = mosi;  assign if8.ss = ss8;
  assign if8.cpol = cpol; assign if8.cpha = cpha;
  assign if8.tx_valid = (tx8_idx != tx8_n);
  assign if8.tx_data  = tx8_words[tx8_idx[2:0]];
  assign if16.sck = sck;   assign if16.mosi = mosi; assign if16.ss = ss16;
  assign if16.cpol = cpol; assign if16.cpha = cpha;
  assign if16.tx_valid = (tx16_idx != tx16_n);
  assign if16.tx_data  = tx16_words[tx16_idx[2:0]];

  logic miso_sel;
  assign miso_sel = sel16 ? if16.miso : if8.miso;

  // Pulse counters and receive logs, sampled mid-cycle.
  int ack8 = 0, und8 = 0, rxv8 = 0, fd8 = 0, fe8 = 0, busy8 = 0;
  int ack16 = 0, und16 = 0, rxv16 = 0, fd16 = 0, fe16 = 0;
  logic [7:0]  rx8_log[8];
  logic [15:0] rx16_log[8];

  always @(negedge clk) begin
    if (if8.tx_ack) begin ack8++; tx8_idx++; end
    if (if8.tx_underrun) und8++;
    if (if8.rx_valid) begin rx8_log[rxv8[2:0]] = if8.rx_data; rxv8++; end
    if (if8.frame_done) fd8++;
    if (if8.frame_done && if8.frame_err) fe8++;
    if (if8.busy) busy8++;
    if (if16.tx_ack) begin ack16++; tx16_idx++; end
    if (if16.tx_underrun) und16++;
    if (if16.rx_valid) begin rx16_log[rxv16[2:0]] = if16.rx_data; rxv16++; end
    if (if16.frame_done) fd16++;
    if (if16.frame_done && if16.frame_err) fe16++;
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push8(input logic [7:0] w);
    tx8_words[tx8_n[2:0]] = w;
    tx8_n++;
  endtask

  task automatic push16(input logic [15:0] w);
    tx16_words[tx16_n[2:0]] = w;
    tx16_n++;
  endtask

  task automatic frame_start(input bit use16, input bit p, input bit h);
    sel16 = use16; cpol = p; cpha = h; sck = p; mosi = 1'b0;
    wait_clk(HALF);
    if (use16) ss16 = 1'b0; else ss8 = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic frame_end();
    wait_clk(HALF);
    ss8 = 1'b1; ss16 = 1'b1;
    wait_clk(2 * HALF);
  endtask

  // Master side of one word: nsend of nbits bits, in the current mode.
  task automatic xfer(input int nbits, input int nsend, input bit lsb,
                      input logic [15:0] mo, output logic [15:0] mi);
    mi = '0;
    for (int i = 0; i < nsend; i++) begin
      int idx;
      idx = lsb ? i : nbits - 1 - i;
      if (!cpha) begin
        mosi = mo[idx]; wait_clk(HALF);
        sck = ~sck; mi[idx] = miso_sel; wait_clk(HALF);
        sck = ~sck;
      end else begin
        sck = ~sck; mosi = mo[idx]; wait_clk(HALF);
        sck = ~sck; mi[idx] = miso_sel; wait_clk(HALF);
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] mi;
    int b_ack, b_und, b_rxv, b_fd, b_fe, b_busy;

    wait_clk(3);
    check("reset_busy", if8.busy, 0);
    check("reset_rx_data", if8.rx_data, 0);
    check("reset_miso", {if8.miso, if8.miso_oe, if16.miso}, 0);
    rst_n = 1'b1;
    wait_clk(5);

    // Mode 0, single word.
    b_ack = ack8; b_und = und8; b_rxv = rxv8; b_fd = fd8; b_fe = fe8;
    push8(8'hA5);
    frame_start(1'b0, 1'b0, 1'b0);
    check("m0_busy", if8.busy, 1);
    xfer(8, 8, 1'b0, 16'h003C, mi);
    frame_end();
    check("m0_master_rx", mi, 16'h00A5);
    check("m0_rx_data", rx8_log[b_rxv[2:0]], 8'h3C);
    check("m0_rx_valid_cnt", rxv8 - b_rxv, 1);
    check("m0_tx_ack_cnt", ack8 - b_ack, 1);
    check("m0_underrun_cnt", und8 - b_und, 1);  // load after the word finds no data
    check("m0_frame_done", fd8 - b_fd, 1);
    check("m0_frame_err", fe8 - b_fe, 0);

    // Mode 3, two-word burst.
    b_ack = ack8; b_und = und8; b_rxv = rxv8;
    push8(8'h12); push8(8'h34);
    frame_start(1'b0, 1'b1, 1'b1);
    xfer(8, 8, 1'b0, 16'h00F0, mi);
    check("m3_master_rx0", mi, 16'h0012);
    xfer(8, 8, 1'b0, 16'h000F, mi);
    check("m3_master_rx1", mi, 16'h0034);
    frame_end();
    check("m3_rx_valid_cnt", rxv8 - b_rxv, 2);
    check("m3_rx0", rx8_log[b_rxv[2:0]], 8'hF0);
    check("m3_rx1", rx8_log[b_rxv[2:0] + 3'd1], 8'h0F);
    check("m3_tx_ack_cnt", ack8 - b_ack, 2);

    // Mode 1, nothing valid at frame start; a spare word arrives mid-frame
    // and is consumed by the load after the word.
    b_ack = ack8; b_und = und8; b_rxv = rxv8;
    frame_start(1'b0, 1'b0, 1'b1);
    push8(8'h77);
    xfer(8, 8, 1'b0, 16'h0081, mi);
    frame_end();
    check("m1_master_rx", mi, 16'h0000);
    check("m1_underrun_cnt", und8 - b_und, 1);
    check("m1_tx_ack_cnt", ack8 - b_ack, 1);
    check("m1_rx_data", if8.rx_data, 8'h81);

    // Mode 2, partial word of 5 bits.
    b_rxv = rxv8; b_fd = fd8; b_fe = fe8;
    frame_start(1'b0, 1'b1, 1'b0);
    xfer(8, 5, 1'b0, 16'h00AA, mi);
    frame_end();
    check("m2_frame_done", fd8 - b_fd, 1);
    check("m2_frame_err", fe8 - b_fe, 1);
    check("m2_rx_valid_cnt", rxv8 - b_rxv, 0);
    check("m2_rx_data_kept", if8.rx_data, 8'h81);
    check("m2_busy_after", if8.busy, 0);

    // 16-bit, LSB first, mode 0.
    b_ack = ack16; b_rxv = rxv16; b_fd = fd16; b_fe = fe16;
    push16(16'h8001);
    frame_start(1'b1, 1'b0, 1'b0);
    xfer(16, 16, 1'b1, 16'h1234, mi);
    frame_end();
    check("w16_master_rx", mi, 16'h8001);
    check("w16_rx_data", if16.rx_data, 16'h1234);
    check("w16_rx_valid_cnt", rxv16 - b_rxv, 1);
    check("w16_tx_ack_cnt", ack16 - b_ack, 1);
    check("w16_frame", {fd16 - b_fd, fe16 - b_fe}, {32'd1, 32'd0});

    // Reset mid-word in mode 0.
    push8(8'h5A);
    frame_start(1'b0, 1'b0, 1'b0);
    xfer(8, 3, 1'b0, 16'h00FF, mi);
    wait_clk(HALF);
    check("rst_pre_busy", if8.busy, 1);
    check("rst_pre_miso", if8.miso, 1);  // bit 4 of 0x5A
    rst_n = 1'b0;
    #1;
    check("rst_outputs", {if8.busy, if8.miso, if8.miso_oe, if8.tx_ack, if8.tx_underrun,
                          if8.rx_valid, if8.frame_done, if8.frame_err}, 0);
    check("rst_rx_data", if8.rx_data, 0);
    wait_clk(3);
    rst_n = 1'b1;
    b_ack = ack8; b_und = und8; b_rxv = rxv8; b_fd = fd8; b_busy = busy8;
    xfer(8, 8, 1'b0, 16'h00FF, mi);
    check("rst_ignored_activity", {ack8 - b_ack, und8 - b_und, rxv8 - b_rxv, fd8 - b_fd}, 0);
    check("rst_ignored_busy", busy8 - b_busy, 0);
    frame_end();
    b_rxv = rxv8; b_fd = fd8; b_fe = fe8;
    push8(8'hC3);
    frame_start(1'b0, 1'b0, 1'b0);
    xfer(8, 8, 1'b0, 16'h0055, mi);
    frame_end();
    check("post_rst_master_rx", mi, 16'h00C3);
    check("post_rst_rx_data", if8.rx_data, 8'h55);
    check("post_rst_rx_valid_cnt", rxv8 - b_rxv, 1);
    check("post_rst_frame", {fd8 - b_fd, fe8 - b_fe}, {32'd1, 32'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
- Parametrised SPI slave: configurable word width, bit order and all four SPI modes (CPOL/CPHA).
- Adds multi-word bursts within one ss frame, valid/ack transmit handshake, underrun and partial-frame error reporting.
- Sits between an external SPI master and on-chip logic (flash model, register bank); all logic runs in the clk domain with synchronised SPI inputs.

Parameters:
DATA_WIDTH, 8, bits per word (>=2)
SYNC_STAGES, 2, synchroniser flops on sck/ss/mosi (>=2)
MSB_FIRST, 1, 1: MSB shifted first on both lines; 0: LSB first

Ports:
clk  input  1  system clock; must be >= 2*(SYNC_STAGES+2) times sck frequency
rst_n  input  1  asynchronous reset, active-low
cpol  input  1  sck idle level; latched at frame start
cpha  input  1  0: sample on leading edge; 1: sample on trailing edge; latched at frame start
tx_data  input  DATA_WIDTH  next word to transmit
tx_valid  input  1  tx_data holds a word; keep stable until tx_ack
tx_ack  output  1  1-cycle pulse: tx_data consumed
tx_underrun  output  1  1-cycle pulse: word load found tx_valid=0; zeros sent
rx_data  output  DATA_WIDTH  last complete received word; held until next word completes
rx_valid  output  1  1-cycle pulse: rx_data updated
busy  output  1  frame in progress (state ACTIVE)
frame_done  output  1  1-cycle pulse on frame end
frame_err  output  1  1-cycle pulse with frame_done if the last word was partial
miso  output  1  serial data out
miso_oe  output  1  pad output enable (= busy)
ss  input  1  slave select, active-low
sck  input  1  serial clock
mosi  input  1  serial data in

Behaviour:
- Reset: all outputs 0; rx_data=0; state IDLE; bit counter 0; shift registers 0.
- Sampling: sck, ss and mosi pass through SYNC_STAGES flops. Edges are detected on synchronised sck.
- Edge roles:
  - Leading edge = rising if cpol_l=0, else falling; the trailing edge is the other one.
  - Sample edge = leading if cpha_l=0, else trailing; shift edge is the other.
- FSM IDLE:
  - miso=0.
  - Synchronised ss falling → ACTIVE. Same cycle: latch cpol/cpha into cpol_l/cpha_l, clear bit_cnt, perform word load.
- Word load:
  - If tx_valid=1: copy tx_data to tx_shift and pulse tx_ack next cycle.
  - Else: tx_shift=0 and pulse tx_underrun.
  - If cpha_l=0: miso = first bit of the loaded word, registered (1-cycle latency).
- ACTIVE, shift edge:
  - cpha_l=1: drive the next bit on miso, including the first bit of each word at its first leading edge.
  - cpha_l=0: drive bits 2..DATA_WIDTH of the word; the first bit comes from the word load.
  - miso updates 1 clk after the detected edge.
- ACTIVE, sample edge:
  - Shift mosi into rx_shift in MSB_FIRST order; bit_cnt += 1.
  - When bit_cnt reaches DATA_WIDTH: rx_data ← completed word and rx_valid pulses 1 clk later; bit_cnt ← 0; word load for the next burst word (cpha_l=0 then presents its first bit on miso immediately).
- ACTIVE, synchronised ss rising → IDLE:
  - Pulse frame_done; pulse frame_err if bit_cnt != 0.
  - Partial rx word discarded (rx_data unchanged, no rx_valid). miso → 0.
- Simultaneous events:
  - ss rising in the same cycle as an sck edge: ss wins and the edge is ignored.
  - A word load and an incoming tx_valid rise in the same cycle count as valid.
- bit_cnt width: $clog2(DATA_WIDTH+1); never exceeds DATA_WIDTH.
- cpol/cpha changes during ACTIVE have no effect until the next frame.
- rx has no backpressure: rx_data is overwritten each word; the consumer must take it within one word time.
- Asynchronous reset mid-frame: immediate return to reset values. A frame still in progress when reset releases is ignored until ss is seen high, then low again.

Test Plan:
- Mode 0, DATA_WIDTH=8, tx 0xA5 valid, master sends 0x3C → master reads 0xA5; rx_data=0x3C with one rx_valid; one tx_ack; frame_done=1, frame_err=0.
- Mode 3, two-word burst in one frame, tx 0x12 then 0x34, master sends 0xF0, 0x0F → master reads 0x12, 0x34; two rx_valid pulses with 0xF0 then 0x0F; two tx_ack.
- Mode 1, tx_valid=0 at frame start, master sends 0x81 → master reads 0x00; tx_underrun pulses once; rx_data=0x81.
- Mode 2, master deasserts ss after 5 bits → frame_done and frame_err pulse; rx_valid stays 0; rx_data keeps its previous value.
- DATA_WIDTH=16, MSB_FIRST=0, mode 0, tx 0x8001, master sends 0x1234 LSB-first → master reads 0x8001 LSB-first; rx_data=0x1234.
- Assert rst_n low mid-word in mode 0 → all outputs 0 immediately; after release with ss still low, no activity until ss toggles high then low; the following 0x55 transfer completes correctly.
